// File: rtl/data_mem_arb_pkg.sv
// Shared definitions for the data memory arbiter.
// Holds the FSM state encodings, port indices, bus widths and the access
// legality check used when a transaction is latched.
package data_mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam int PORT_CORE = 0;
  localparam int PORT_DBG  = 1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_DONE   = 2'd2;

  // An access is rejected when it is not word aligned or falls past the end
  // of the memory (limit is the size of the memory in bytes).
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a,
                                    input logic [ADDR_W-1:0] limit);
    return (a[1:0] != 2'b00) || (a >= limit);
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-requester arbiter, purely combinational.
// Ports:
//   req        in  2  per-port request
//   last       in  1  port that won the previous transaction
//   fixed_prio in  1  1 = port 0 always wins a tie
//   gnt        out 2  one-hot grant, zero when nobody requests
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed_prio,
  output logic [1:0] gnt
);

  // On a tie the port that did not win last time goes next (unless fixed).
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11: begin
        if (fixed_prio || last) begin
          gnt = 2'b01;
        end else begin
          gnt = 2'b10;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbiter sharing one single-port word-addressed data memory between the
// core load/store unit (port 0) and the loader/debug port (port 1).
// Each access runs IDLE -> ACCESS -> DONE with a one-cycle ack pulse.
// Ports:
//   Clk, reset                       clock, synchronous active-high reset
//   req/we [1:0]                     per-port request and write enable
//   addr0/addr1, wdata0/wdata1       per-port byte address and store data
//   ack/err [1:0], rdata             completion pulse, reject flag, load data
//   MemAddress/MemWriteData          memory address and write data
//   MemWrite/MemRead                 memory strobes (only high in ACCESS)
//   MemReadData                      memory read data (combinational)
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic [1:0]        err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] MemReadData
);

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH * 4);

  state_t            r_state;
  state_t            w_next;
  logic              r_last;
  logic              r_win;
  logic              r_we;
  logic              r_bad;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_ack;
  logic [1:0]        r_err;
  logic [DATA_W-1:0] r_rdata;

  logic [1:0]        w_gnt;
  logic              w_win;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_win_oh;

  rr_arb2 u_arb (
    .req        (req),
    .last       (r_last),
    .fixed_prio (FIXED_PRIO),
    .gnt        (w_gnt)
  );

  assign w_win    = w_gnt[PORT_DBG];
  assign w_addr   = w_win ? addr1 : addr0;
  assign w_win_oh = r_win ? 2'b10 : 2'b01;

  // State register.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: one transaction in flight, fixed three-cycle walk.
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (req != 2'b00) begin
          w_next = ST_ACCESS;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_ACCESS: w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Transaction latch and response registers; inputs only sampled in IDLE.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_last  <= 1'b1;
      r_win   <= 1'b0;
      r_we    <= 1'b0;
      r_bad   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ack   <= 2'b00;
      r_err   <= 2'b00;
      r_rdata <= '0;
    end else begin
      r_ack <= 2'b00;
      r_err <= 2'b00;
      case (r_state)
        ST_IDLE: begin
          if (req != 2'b00) begin
            r_win   <= w_win;
            r_we    <= we[w_win];
            r_addr  <= w_addr;
            r_wdata <= w_win ? wdata1 : wdata0;
            r_bad   <= addr_bad(w_addr, LIMIT);
          end
        end
        ST_ACCESS: begin
          r_ack   <= w_win_oh;
          r_err   <= r_bad ? w_win_oh : 2'b00;
          r_rdata <= (!r_we && !r_bad) ? MemReadData : '0;
        end
        ST_DONE: r_last <= r_win;
        default: r_last <= r_last;
      endcase
    end
  end

  // Memory strobes decode the state; reset blocks a write at the closing edge.
  always_comb begin
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    if (r_state == ST_ACCESS && !r_bad && !reset) begin
      MemWrite = r_we;
      MemRead  = !r_we;
    end else begin
      MemWrite = 1'b0;
      MemRead  = 1'b0;
    end
  end

  assign MemAddress   = r_addr;
  assign MemWriteData = r_wdata;
  assign ack          = r_ack;
  assign err          = r_err;
  assign rdata        = r_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
  } sb_t;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [31:0] addr0 = 32'h0, addr1 = 32'h0, wdata0 = 32'h0, wdata1 = 32'h0;
  logic [1:0]  ack, err;
  logic [31:0] rdata, MemAddress, MemWriteData, MemReadData;
  logic        MemWrite, MemRead;

  // Second instance with fixed priority for grant-order checking.
  logic [1:0]  req_f = 2'b00;
  logic [1:0]  ack_f, err_f;
  logic [31:0] rdata_f, MemAddress_f, MemWriteData_f;
  logic [31:0] MemReadData_f = 32'h0;
  logic        MemWrite_f, MemRead_f;

  logic [31:0] mem [0:31];
  sb_t         sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;

  always #5 Clk = ~Clk;

  data_mem_arbiter #(.DEPTH(32), .FIXED_PRIO(1'b0)) dut (
    .Clk(Clk), .reset(reset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .err(err), .rdata(rdata),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData)
  );

  data_mem_arbiter #(.DEPTH(32), .FIXED_PRIO(1'b1)) dut_f (
    .Clk(Clk), .reset(reset), .req(req_f), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack_f), .err(err_f), .rdata(rdata_f),
    .MemAddress(MemAddress_f), .MemWriteData(MemWriteData_f),
    .MemWrite(MemWrite_f), .MemRead(MemRead_f), .MemReadData(MemReadData_f)
  );

  // Behavioural single-port memory: synchronous write, combinational read.
  assign MemReadData = MemRead ? mem[MemAddress[6:2]] : 32'h0;

  always @(posedge Clk) begin
    if (MemWrite) mem[MemAddress[6:2]] <= MemWriteData;
  end

  // Strobe monitor.
  always @(negedge Clk) begin
    if (MemRead) rd_cnt++;
    if (MemWrite) wr_cnt++;
    if (MemRead && MemWrite) both_cnt++;
  end

  task automatic do_reset();
    @(negedge Clk);
    reset = 1'b1;
    req = 2'b00;
    req_f = 2'b00;
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    reset = 1'b0;
  endtask

  // One transaction on one port; checks latency, strobes and the scoreboard.
  task automatic txn(input int p, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic e_err,
                     input logic [31:0] e_rd, input logic drop_mid,
                     input string name);
    sb_t         it;
    sb_t         ex;
    int          cyc;
    logic        saw_wr, saw_rd;
    logic [1:0]  e_ack;
    it.port = p; it.err = e_err; it.rdata = e_rd;
    sb.push_back(it);
    cyc = 0; saw_wr = 1'b0; saw_rd = 1'b0;
    @(negedge Clk);
    if (p == 0) begin addr0 = a; wdata0 = d; end
    else        begin addr1 = a; wdata1 = d; end
    we[p] = w;
    req[p] = 1'b1;
    while (cyc < 8) begin
      @(negedge Clk);
      cyc++;
      if (cyc == 1) begin
        saw_wr = MemWrite;
        saw_rd = MemRead;
        if (drop_mid) req[p] = 1'b0;
      end
      if (ack != 2'b00) break;
    end
    req[p] = 1'b0;
    ex = sb.pop_front();
    e_ack = (ex.port == 0) ? 2'b01 : 2'b10;
    n_chk++;
    if (ack !== e_ack) begin
      n_fail++;
      $display("FAIL %s ack: got %b expected %b", name, ack, e_ack);
    end
    n_chk++;
    if (err !== (ex.err ? e_ack : 2'b00)) begin
      n_fail++;
      $display("FAIL %s err: got %b expected %b", name, err, ex.err ? e_ack : 2'b00);
    end
    n_chk++;
    if (rdata !== ex.rdata) begin
      n_fail++;
      $display("FAIL %s rdata: got %h expected %h", name, rdata, ex.rdata);
    end
    n_chk++;
    if (cyc != 2) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected 2", name, cyc);
    end
    n_chk++;
    if (saw_wr !== (w & ~e_err) || saw_rd !== (~w & ~e_err)) begin
      n_fail++;
      $display("FAIL %s strobes: got wr=%b rd=%b expected wr=%b rd=%b",
               name, saw_wr, saw_rd, w & ~e_err, ~w & ~e_err);
    end
  endtask

  task automatic test_reset();
    @(negedge Clk);
    reset = 1'b1;
    req = 2'b11;
    we = 2'b01;
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    n_chk++;
    if (ack !== 2'b00 || MemWrite !== 1'b0 || MemRead !== 1'b0 ||
        rdata !== 32'h0 || MemAddress !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: got ack=%b wr=%b rd=%b rdata=%h addr=%h expected all zero",
               ack, MemWrite, MemRead, rdata, MemAddress);
    end
    req = 2'b00;
    we = 2'b00;
    reset = 1'b0;
  endtask

  task automatic test_store_load();
    txn(0, 1'b1, 32'h8, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, "store0");
    txn(0, 1'b0, 32'h8, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, "load0");
    txn(1, 1'b1, 32'h7C, 32'h0BADF00D, 1'b0, 32'h0, 1'b0, "store1_last_word");
    txn(1, 1'b0, 32'h7C, 32'h0, 1'b0, 32'h0BADF00D, 1'b0, "load1_last_word");
  endtask

  // Both ports keep requesting; checks the order in which acks come back.
  task automatic grant_order(input logic fixed, input int n, input string name);
    sb_t  it;
    sb_t  ex;
    int   got;
    int   cyc;
    logic [1:0] a;
    do_reset();
    we = 2'b00;
    addr0 = 32'h8;
    addr1 = 32'hC;
    for (int i = 0; i < n; i++) begin
      it.port = fixed ? 0 : (i % 2); it.err = 1'b0; it.rdata = 32'h0;
      sb.push_back(it);
    end
    if (fixed) req_f = 2'b11; else req = 2'b11;
    for (int i = 0; i < n; i++) begin
      cyc = 0;
      a = 2'b00;
      while (cyc < 8) begin
        @(negedge Clk);
        cyc++;
        a = fixed ? ack_f : ack;
        if (a != 2'b00) break;
      end
      ex = sb.pop_front();
      got = (a == 2'b01) ? 0 : (a == 2'b10) ? 1 : -1;
      n_chk++;
      if (got != ex.port) begin
        n_fail++;
        $display("FAIL %s grant %0d: got port %0d (ack=%b) expected port %0d",
                 name, i, got, a, ex.port);
      end
      if (got >= 0) begin
        if (fixed) req_f[got] = 1'b0; else req[got] = 1'b0;
        @(negedge Clk);
        if (fixed) req_f[got] = 1'b1; else req[got] = 1'b1;
      end
    end
    req = 2'b00;
    req_f = 2'b00;
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_bad_access();
    int rd0, wr0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    txn(1, 1'b0, 32'h6, 32'h0, 1'b1, 32'h0, 1'b0, "load1_misaligned");
    txn(1, 1'b0, 32'h80, 32'h0, 1'b1, 32'h0, 1'b0, "load1_out_of_range");
    txn(0, 1'b1, 32'h80, 32'h12345678, 1'b1, 32'h0, 1'b0, "store0_out_of_range");
    n_chk++;
    if (rd_cnt != rd0 || wr_cnt != wr0) begin
      n_fail++;
      $display("FAIL bad_strobes: got rd=%0d wr=%0d cycles expected 0 0",
               rd_cnt - rd0, wr_cnt - wr0);
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    txn(0, 1'b1, 32'h4, 32'h11111111, 1'b0, 32'h0, 1'b0, "store0_pre");
    @(negedge Clk);
    addr0 = 32'h4;
    wdata0 = 32'h22222222;
    we[0] = 1'b1;
    req[0] = 1'b1;
    @(negedge Clk);
    reset = 1'b1;
    #1;
    n_chk++;
    if (MemWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_memwrite: got %b expected 0", MemWrite);
    end
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (ack != 2'b00) acks++;
      req = 2'b00;
      if (i == 1) reset = 1'b0;
    end
    n_chk++;
    if (acks != 0) begin
      n_fail++;
      $display("FAIL reset_mid_ack: got %0d ack cycles expected 0", acks);
    end
    txn(0, 1'b0, 32'h4, 32'h0, 1'b0, 32'h11111111, 1'b0, "load0_after_reset");
  endtask

  task automatic test_drop_mid();
    txn(1, 1'b0, 32'h8, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, "load1_drop_mid");
    @(negedge Clk);
    n_chk++;
    if (ack !== 2'b00 || MemRead !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_mid_idle: got ack=%b rd=%b expected 00 0", ack, MemRead);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    test_reset();
    test_store_load();
    grant_order(1'b0, 4, "round_robin");
    grant_order(1'b1, 3, "fixed_prio");
    test_bad_access();
    test_reset_mid();
    test_drop_mid();
    n_chk++;
    if (both_cnt != 0) begin
      n_fail++;
      $display("FAIL strobe_exclusive: got %0d cycles with both strobes expected 0", both_cnt);
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
